lc3b_decode_stage: RTL and testbench

//  ID stage of the pipelined LC-3b. Takes the fetched {pc, inst} from IF, builds an lc3b_ipacket
//  and holds it in the ID/EX register for the EX stage. Detects load-use hazards against the

---
 rtl/lc3b_types.sv | 170 +++++++++++++++++
 rtl/lc3b_hazard_unit.sv | 25 ++
 rtl/lc3b_decode_stage.sv | 89 ++++++++
 tb/tb_lc3b_decode_stage.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: opcodes, ALU ops, mux-select encodings, the
// ID/EX instruction packet and the instruction decoder.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef enum logic [3:0] {
        op_br  = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb  = 4'b0011,
        op_jsr = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str  = 4'b0111,
        op_rti = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti  = 4'b1011,
        op_jmp = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;

    localparam logic       SEL_SR2MUX_REG     = 1'b0;
    localparam logic       SEL_SR2MUX_IMM5    = 1'b1;
    localparam logic       SEL_ALUMUX_SR2     = 1'b0;
    localparam logic       SEL_ALUMUX_IMM4    = 1'b1;
    localparam logic       SEL_BRADDMUX_OFF9  = 1'b0;
    localparam logic       SEL_BRADDMUX_OFF11 = 1'b1;
    localparam logic [1:0] SEL_PCMUX_PLUS2    = 2'd0;
    localparam logic [1:0] SEL_PCMUX_BR       = 2'd1;
    localparam logic [1:0] SEL_PCMUX_REG      = 2'd2;
    localparam logic [1:0] SEL_PCMUX_TRAP     = 2'd3;
    localparam logic       SEL_DRMUX_IR       = 1'b0;
    localparam logic       SEL_DRMUX_R7       = 1'b1;
    localparam logic       SEL_CCMUX_ALU      = 1'b0;
    localparam logic       SEL_CCMUX_WDATA    = 1'b1;
    localparam logic       SEL_DATAMUX_WORD   = 1'b0;
    localparam logic       SEL_DATAMUX_BYTE   = 1'b1;
    localparam logic [1:0] SEL_RFMUX_ALU      = 2'd0;
    localparam logic [1:0] SEL_RFMUX_MEM      = 2'd1;
    localparam logic [1:0] SEL_RFMUX_PC       = 2'd2;
    localparam logic [1:0] SEL_RFMUX_BRADD    = 2'd3;
    localparam logic       SEL_WDATAMUX_WORD  = 1'b0;
    localparam logic       SEL_WDATAMUX_BYTE  = 1'b1;
    localparam logic [1:0] SEL_ADDRMUX_ALU    = 2'd0;
    localparam logic [1:0] SEL_ADDRMUX_MDR    = 2'd1;
    localparam logic [1:0] SEL_ADDRMUX_TRAP   = 2'd2;

    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_word   pc;
        lc3b_word   inst;
        lc3b_reg    dr_sr;
        lc3b_reg    sr1;
        lc3b_reg    sr2;
        logic [2:0] nzp;
        lc3b_aluop  aluop;
        logic       sr2_mux_sel;
        logic       alumux_sel;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       byte_op;
        logic       braddmux_sel;
        logic [1:0] pcmux_sel;
        logic       drmux_sel;
        logic       cc_mux_sel;
        logic       datamux_sel;
        logic [1:0] regfile_mux_sel;
        logic       wdatamux_sel;
        logic [1:0] addrmux_sel;
    } lc3b_ipacket;

    function automatic logic uses_src1(lc3b_word inst);
        lc3b_opcode op = lc3b_opcode'(inst[15:12]);
        return !(op == op_br || op == op_lea || op == op_trap || (op == op_jsr && inst[11]));
    endfunction

    function automatic logic uses_src2(lc3b_word inst);
        lc3b_opcode op = lc3b_opcode'(inst[15:12]);
        return ((op == op_add || op == op_and) && !inst[5]) ||
               op == op_stb || op == op_str || op == op_sti;
    endfunction

    function automatic lc3b_reg src2_reg(lc3b_word inst);
        lc3b_opcode op = lc3b_opcode'(inst[15:12]);
        return (op == op_add || op == op_and) ? inst[2:0] : inst[11:9];
    endfunction

    function automatic lc3b_ipacket lc3b_decode(lc3b_word pc, lc3b_word inst);
        lc3b_ipacket p;
        lc3b_opcode  op = lc3b_opcode'(inst[15:12]);
        p        = '0;
        p.opcode = op;
        p.pc     = pc;
        p.inst   = inst;
        p.sr1    = inst[8:6];
        p.nzp    = inst[11:9];
        p.dr_sr  = (op == op_jsr || op == op_trap) ? 3'd7 : inst[11:9];
        p.sr2    = uses_src2(inst) ? src2_reg(inst) : 3'd0;
        p.aluop  = alu_pass;
        case (op)
            op_add, op_and: begin
                p.aluop        = (op == op_add) ? alu_add : alu_and;
                p.sr2_mux_sel  = inst[5] ? SEL_SR2MUX_IMM5 : SEL_SR2MUX_REG;
                p.load_regfile = 1'b1;
                p.load_cc      = 1'b1;
            end
            op_not: begin
                p.aluop        = alu_not;
                p.load_regfile = 1'b1;
                p.load_cc      = 1'b1;
            end
            op_shf: begin
                p.aluop        = !inst[4] ? alu_sll : (inst[5] ? alu_sra : alu_srl);
                p.alumux_sel   = SEL_ALUMUX_IMM4;
                p.load_regfile = 1'b1;
                p.load_cc      = 1'b1;
            end
            op_ldb, op_ldr, op_ldi: begin
                p.mem_read        = 1'b1;
                p.load_regfile    = 1'b1;
                p.load_cc         = 1'b1;
                p.byte_op         = (op == op_ldb);
                p.datamux_sel     = (op == op_ldb) ? SEL_DATAMUX_BYTE : SEL_DATAMUX_WORD;
                p.regfile_mux_sel = SEL_RFMUX_MEM;
                p.cc_mux_sel      = SEL_CCMUX_WDATA;
                p.addrmux_sel     = (op == op_ldi) ? SEL_ADDRMUX_MDR : SEL_ADDRMUX_ALU;
            end
            op_stb, op_str: begin
                p.mem_write    = 1'b1;
                p.byte_op      = (op == op_stb);
                p.wdatamux_sel = (op == op_stb) ? SEL_WDATAMUX_BYTE : SEL_WDATAMUX_WORD;
            end
            op_sti: begin
                // Indirect store reads the pointer before writing through it.
                p.mem_read    = 1'b1;
                p.mem_write   = 1'b1;
                p.addrmux_sel = SEL_ADDRMUX_MDR;
            end
            op_lea: begin
                p.load_regfile    = 1'b1;
                p.load_cc         = 1'b1;
                p.braddmux_sel    = SEL_BRADDMUX_OFF9;
                p.regfile_mux_sel = SEL_RFMUX_BRADD;
                p.cc_mux_sel      = SEL_CCMUX_WDATA;
            end
            op_br: begin
                p.braddmux_sel = SEL_BRADDMUX_OFF9;
                p.pcmux_sel    = SEL_PCMUX_BR;
            end
            op_jsr: begin
                p.load_regfile    = 1'b1;
                p.drmux_sel       = SEL_DRMUX_R7;
                p.regfile_mux_sel = SEL_RFMUX_PC;
                p.braddmux_sel    = SEL_BRADDMUX_OFF11;
                p.pcmux_sel       = inst[11] ? SEL_PCMUX_BR : SEL_PCMUX_REG;
            end
            op_jmp: p.pcmux_sel = SEL_PCMUX_REG;
            op_trap: begin
                p.load_regfile    = 1'b1;
                p.mem_read        = 1'b1;
                p.drmux_sel       = SEL_DRMUX_R7;
                p.regfile_mux_sel = SEL_RFMUX_PC;
                p.pcmux_sel       = SEL_PCMUX_TRAP;
                p.addrmux_sel     = SEL_ADDRMUX_TRAP;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/lc3b_hazard_unit.sv
// Load-use hazard detect: the offered instruction reads the register that the
// load currently in EX has not yet written back.
module lc3b_hazard_unit
    import lc3b_types::*;
(
    input  logic        if_valid,
    input  logic [15:0] if_inst,
    input  logic        ex_valid,
    input  lc3b_ipacket ex_packet,
    output logic        hazard
);

    logic src1_hit;
    logic src2_hit;
    logic unused_bits;

    assign src1_hit = uses_src1(if_inst) && (if_inst[8:6] == ex_packet.dr_sr);
    assign src2_hit = uses_src2(if_inst) && (src2_reg(if_inst) == ex_packet.dr_sr);

    assign hazard = if_valid && ex_valid && ex_packet.mem_read && ex_packet.load_regfile &&
                    (src1_hit || src2_hit);

    assign unused_bits = ^{ex_packet, if_inst};

endmodule

// File: rtl/lc3b_decode_stage.sv
// LC-3b ID stage: decodes {pc, inst} into the ID/EX packet register and inserts
// a single bubble on a load-use hazard against the instruction in EX.
module lc3b_decode_stage
    import lc3b_types::*;
#(
    parameter bit BUBBLE_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_pc,
    input  logic [15:0] if_inst,
    input  logic        flush,
    input  lc3b_ipacket ex_packet,
    input  logic        ex_valid,
    output logic        id_valid,
    input  logic        id_ready,
    output lc3b_ipacket id_packet
);

    typedef enum logic [0:0] {StRun, StStall} hz_state_e;

    hz_state_e   state_q, state_d;
    logic        id_valid_q, id_valid_d;
    lc3b_ipacket id_packet_q, id_packet_d;
    lc3b_ipacket decoded;
    logic        hazard_raw;
    logic        hazard;
    logic        room;

    lc3b_hazard_unit u_hazard (
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .ex_valid  (ex_valid),
        .ex_packet (ex_packet),
        .hazard    (hazard_raw)
    );

    // In StStall the load has moved past EX, so the compare is ignored.
    assign hazard   = hazard_raw && (state_q == StRun);
    assign room     = !id_valid_q || id_ready;
    assign if_ready = !flush && !hazard && room;

    always_comb begin
        decoded = lc3b_decode(if_pc, if_inst);
        if (BUBBLE_ON_ILLEGAL && decoded.opcode == op_rti) begin
            decoded        = '0;
            decoded.opcode = op_rti;
            decoded.pc     = if_pc;
            decoded.inst   = if_inst;
        end
    end

    always_comb begin
        state_d     = StRun;
        id_valid_d  = id_valid_q;
        id_packet_d = id_packet_q;
        if (flush) begin
            id_valid_d  = 1'b0;
            id_packet_d = '0;
        end else if (hazard && room) begin
            id_valid_d  = 1'b1;
            id_packet_d = '0;
            state_d     = StStall;
        end else if (if_valid && if_ready) begin
            id_valid_d  = 1'b1;
            id_packet_d = decoded;
        end else if (id_ready) begin
            id_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            id_valid_q  <= 1'b0;
            id_packet_q <= '0;
        end else begin
            state_q     <= state_d;
            id_valid_q  <= id_valid_d;
            id_packet_q <= id_packet_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_packet = id_packet_q;

endmodule

// File: tb/tb_lc3b_decode_stage.sv
// Self-checking bench for lc3b_decode_stage: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_lc3b_decode_stage;
    import lc3b_types::*;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_pc;
    logic [15:0] if_inst;
    logic        flush;
    lc3b_ipacket ex_packet;
    logic        ex_valid;
    logic        id_valid;
    logic        id_ready;
    lc3b_ipacket id_packet;

    int errors = 0;
    int checks = 0;

    lc3b_decode_stage #(.BUBBLE_ON_ILLEGAL(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .flush     (flush),
        .ex_packet (ex_packet),
        .ex_valid  (ex_valid),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_packet (id_packet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference decode written from the opcode-membership rules.
    function automatic lc3b_ipacket ref_decode(logic [15:0] pc, logic [15:0] inst);
        lc3b_ipacket p;
        logic [3:0]  op = inst[15:12];
        p        = '0;
        p.opcode = lc3b_opcode'(op);
        p.pc     = pc;
        p.inst   = inst;
        if (op == 4'd8) return p;
        p.sr1   = inst[8:6];
        p.nzp   = inst[11:9];
        p.dr_sr = (op inside {4'd4, 4'd15}) ? 3'd7 : inst[11:9];
        if (op inside {4'd1, 4'd5} && !inst[5]) p.sr2 = inst[2:0];
        else if (op inside {4'd3, 4'd7, 4'd11}) p.sr2 = inst[11:9];
        p.aluop = (op == 4'd1) ? alu_add : (op == 4'd5) ? alu_and : (op == 4'd9) ? alu_not :
                  (op == 4'd13) ? (!inst[4] ? alu_sll : (inst[5] ? alu_sra : alu_srl)) : alu_pass;
        p.sr2_mux_sel  = (op inside {4'd1, 4'd5}) && inst[5];
        p.alumux_sel   = (op == 4'd13);
        p.load_regfile = op inside {4'd1, 4'd5, 4'd9, 4'd13, 4'd2, 4'd6, 4'd10, 4'd14, 4'd4, 4'd15};
        p.load_cc      = op inside {4'd1, 4'd5, 4'd9, 4'd13, 4'd2, 4'd6, 4'd10, 4'd14};
        p.mem_read     = op inside {4'd2, 4'd6, 4'd10, 4'd11, 4'd15};
        p.mem_write    = op inside {4'd3, 4'd7, 4'd11};
        p.byte_op      = op inside {4'd2, 4'd3};
        p.braddmux_sel = (op == 4'd4) ? SEL_BRADDMUX_OFF11 : SEL_BRADDMUX_OFF9;
        p.pcmux_sel    = (op == 4'd0) ? SEL_PCMUX_BR :
                         (op == 4'd4) ? (inst[11] ? SEL_PCMUX_BR : SEL_PCMUX_REG) :
                         (op == 4'd12) ? SEL_PCMUX_REG : (op == 4'd15) ? SEL_PCMUX_TRAP :
                         SEL_PCMUX_PLUS2;
        p.drmux_sel    = (op inside {4'd4, 4'd15}) ? SEL_DRMUX_R7 : SEL_DRMUX_IR;
        p.cc_mux_sel   = (op inside {4'd2, 4'd6, 4'd10, 4'd14}) ? SEL_CCMUX_WDATA : SEL_CCMUX_ALU;
        p.datamux_sel  = (op == 4'd2) ? SEL_DATAMUX_BYTE : SEL_DATAMUX_WORD;
        p.regfile_mux_sel = (op inside {4'd2, 4'd6, 4'd10}) ? SEL_RFMUX_MEM :
                            (op inside {4'd4, 4'd15}) ? SEL_RFMUX_PC :
                            (op == 4'd14) ? SEL_RFMUX_BRADD : SEL_RFMUX_ALU;
        p.wdatamux_sel = (op == 4'd3) ? SEL_WDATAMUX_BYTE : SEL_WDATAMUX_WORD;
        p.addrmux_sel  = (op inside {4'd10, 4'd11}) ? SEL_ADDRMUX_MDR :
                         (op == 4'd15) ? SEL_ADDRMUX_TRAP : SEL_ADDRMUX_ALU;
        return p;
    endfunction

    // Does the instruction read register r as a source operand?
    function automatic bit reads_reg(logic [15:0] inst, logic [2:0] r);
        logic [3:0] op = inst[15:12];
        logic [2:0] srcs[$];
        if (!(op == 4'd0 || op == 4'd14 || op == 4'd15 || (op == 4'd4 && inst[11])))
            srcs.push_back(inst[8:6]);
        if (op inside {4'd1, 4'd5} && !inst[5]) srcs.push_back(inst[2:0]);
        if (op inside {4'd3, 4'd7, 4'd11}) srcs.push_back(inst[11:9]);
        foreach (srcs[i]) if (srcs[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid  = 1'b0;
        if_pc     = 16'h0;
        if_inst   = 16'h0;
        flush     = 1'b0;
        ex_packet = '0;
        ex_valid  = 1'b0;
        id_ready  = 1'b1;
    endtask

    task automatic issue(input logic [15:0] pc, input logic [15:0] inst);
        if_pc    = pc;
        if_inst  = inst;
        if_valid = 1'b1;
        id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", id_valid);
        end
        checks++;
        if (id_packet !== lc3b_ipacket'('0)) begin
            errors++; $display("FAIL reset_packet: got %h want 0", id_packet);
        end
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL reset_if_ready: got %b want 1", if_ready);
        end
    endtask

    task automatic test_add();
        if_pc = 16'h3000; if_inst = 16'h12BD; if_valid = 1'b1; id_ready = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL add_if_ready: got %b want 1", if_ready);
        end
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_packet.dr_sr !== 3'd1 || id_packet.sr1 !== 3'd2 ||
            id_packet.sr2_mux_sel !== 1'b1 || id_packet.aluop !== alu_add ||
            id_packet.load_regfile !== 1'b1 || id_packet.load_cc !== 1'b1) begin
            errors++;
            $display("FAIL add_fields: got v=%b dr=%0d sr1=%0d imm=%b alu=%0d lr=%b lcc=%b want 1 1 2 1 0 1 1",
                     id_valid, id_packet.dr_sr, id_packet.sr1, id_packet.sr2_mux_sel,
                     id_packet.aluop, id_packet.load_regfile, id_packet.load_cc);
        end
        checks++;
        if (id_packet !== ref_decode(16'h3000, 16'h12BD)) begin
            errors++;
            $display("FAIL add_packet: got %h want %h", id_packet, ref_decode(16'h3000, 16'h12BD));
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL add_drain: got %b want 0", id_valid);
        end
    endtask

    task automatic test_store_jsr_trap();
        issue(16'h3002, 16'h3441);
        checks++;
        if (id_packet.sr2 !== 3'd2 || id_packet.mem_write !== 1'b1 || id_packet.byte_op !== 1'b1
            || id_packet.load_regfile !== 1'b0 || id_packet.load_cc !== 1'b0) begin
            errors++;
            $display("FAIL stb_fields: got sr2=%0d mw=%b bo=%b lr=%b lcc=%b want 2 1 1 0 0",
                     id_packet.sr2, id_packet.mem_write, id_packet.byte_op,
                     id_packet.load_regfile, id_packet.load_cc);
        end
        issue(16'h3004, 16'h4805);
        checks++;
        if (id_packet.dr_sr !== 3'd7 || id_packet.load_regfile !== 1'b1) begin
            errors++;
            $display("FAIL jsr_fields: got dr=%0d lr=%b want 7 1",
                     id_packet.dr_sr, id_packet.load_regfile);
        end
        issue(16'h3006, 16'hF025);
        checks++;
        if (id_packet.dr_sr !== 3'd7 || id_packet.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL trap_fields: got dr=%0d mr=%b want 7 1",
                     id_packet.dr_sr, id_packet.mem_read);
        end
        issue(16'h3008, 16'h8000);
        checks++;
        if (id_packet !== ref_decode(16'h3008, 16'h8000)) begin
            errors++;
            $display("FAIL rti_nop: got %h want %h", id_packet, ref_decode(16'h3008, 16'h8000));
        end
        tick();
    endtask

    task automatic test_load_use();
        ex_packet = ref_decode(16'h0, 16'h6700);
        ex_valid  = 1'b1;
        if_pc = 16'h3010; if_inst = 16'h1AC3; if_valid = 1'b1; id_ready = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL lu_stall_ready: got %b want 0", if_ready);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_packet !== lc3b_ipacket'('0)) begin
            errors++; $display("FAIL lu_bubble: got v=%b p=%h want v=1 p=0", id_valid, id_packet);
        end
        ex_packet = '0;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL lu_resume_ready: got %b want 1", if_ready);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_packet !== ref_decode(16'h3010, 16'h1AC3)) begin
            errors++;
            $display("FAIL lu_issue: got v=%b p=%h want v=1 p=%h", id_valid, id_packet,
                     ref_decode(16'h3010, 16'h1AC3));
        end
        ex_packet = ref_decode(16'h0, 16'h1660);
        if_pc = 16'h3012;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL alu_no_stall: got %b want 1", if_ready);
        end
        tick();
        checks++;
        if (id_packet !== ref_decode(16'h3012, 16'h1AC3)) begin
            errors++;
            $display("FAIL alu_issue: got %h want %h", id_packet, ref_decode(16'h3012, 16'h1AC3));
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hold();
        issue(16'h0100, 16'h5042);
        id_ready = 1'b0;
        if_pc = 16'h0102; if_inst = 16'h9FFF; if_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (if_ready !== 1'b0) begin
                errors++; $display("FAIL hold_if_ready[%0d]: got %b want 0", i, if_ready);
            end
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_packet !== ref_decode(16'h0100, 16'h5042)) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v=%b p=%h want v=1 p=%h", i, id_valid,
                         id_packet, ref_decode(16'h0100, 16'h5042));
            end
        end
        id_ready = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release_ready: got %b want 1", if_ready);
        end
        tick();
        if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b1 || id_packet !== ref_decode(16'h0102, 16'h9FFF)) begin
            errors++;
            $display("FAIL hold_next_issue: got v=%b p=%h want v=1 p=%h", id_valid, id_packet,
                     ref_decode(16'h0102, 16'h9FFF));
        end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL hold_drain: got %b want 0", id_valid);
        end
    endtask

    task automatic test_flush();
        issue(16'h0200, 16'h1261);
        id_ready = 1'b0;
        if_pc = 16'h0202; if_inst = 16'h1483; if_valid = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL flush_if_ready: got %b want 0", if_ready);
        end
        tick();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_hold: got %b want 0", id_valid);
        end
        // Enter STALL, then flush it.
        ex_packet = ref_decode(16'h0, 16'h6700); ex_valid = 1'b1;
        if_pc = 16'h0204; if_inst = 16'h1AC3; if_valid = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %b want 0", id_valid);
        end
        #1;
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL flush_stall_run: got if_ready=%b want 0", if_ready);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: got v=%b rdy=%b want 0 0", id_valid, if_ready);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic        m_valid;
        logic        m_stall;
        lc3b_ipacket m_pkt;
        logic        hz, room, exp_rdy;
        logic [3:0]  ex_ops [5];
        logic [15:0] ex_inst;
        ex_ops = '{4'd2, 4'd6, 4'd10, 4'd15, 4'd1};
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_valid = 1'b0; m_stall = 1'b0; m_pkt = '0;
        for (int c = 0; c < 2000; c++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if_pc    = 16'($urandom);
            if_inst  = 16'($urandom);
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_inst  = {ex_ops[$urandom_range(0, 4)], 12'($urandom)};
            ex_packet = ref_decode(16'h0, ex_inst);
            #1;
            hz = !m_stall && if_valid && ex_valid && ex_packet.mem_read &&
                 ex_packet.load_regfile && reads_reg(if_inst, ex_packet.dr_sr);
            room    = !m_valid || id_ready;
            exp_rdy = !flush && !hz && room;
            checks++;
            if (if_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_if_ready[%0d]: got %b want %b", c, if_ready, exp_rdy);
            end
            if (flush) begin
                m_valid = 1'b0; m_stall = 1'b0;
            end else if (hz && room) begin
                m_valid = 1'b1; m_pkt = '0; m_stall = 1'b1;
            end else begin
                m_stall = 1'b0;
                if (if_valid && exp_rdy) begin
                    m_valid = 1'b1; m_pkt = ref_decode(if_pc, if_inst);
                end else if (id_ready) begin
                    m_valid = 1'b0;
                end
            end
            tick();
            checks++;
            if (id_valid !== m_valid) begin
                errors++; $display("FAIL rnd_id_valid[%0d]: got %b want %b", c, id_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (id_packet !== m_pkt) begin
                    errors++;
                    $display("FAIL rnd_packet[%0d]: got %h want %h", c, id_packet, m_pkt);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_add();
        test_store_jsr_trap();
        test_load_use();
        test_hold();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
